// File: rtl/rom_burst_reader_sv.sv
// Burst sequencer for a 1-cycle-latency synchronous ROM, streaming words over valid/ready.
// Optional stall counter output stall_cnt_o is enabled by defining ROM_READER_STALL_CNT_EN.
module rom_burst_reader_sv #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
`ifdef ROM_READER_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] romAddr_q, romAddr_d;
    logic [LEN_WIDTH-1:0]  issueCnt_q, issueCnt_d;
    logic [LEN_WIDTH-1:0]  beatCnt_q, beatCnt_d;
    logic                  inflight_q, inflight_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  headLast_q, headLast_d, tailLast_q, tailLast_d;
    logic [1:0]            occ_q, occ_d;

    logic       pop;
    logic       push;
    logic       pushLast;
    logic       issue;
    logic [2:0] pending;

    assign valid_o    = (occ_q != 2'd0);
    assign data_o     = head_q;
    assign last_o     = valid_o & headLast_q;
    assign busy_o     = busy_q;
    assign done_o     = (state_q == DONE);
    assign rom_addr_o = romAddr_q;

    assign pop  = valid_o & ready_i;
    assign push = inflight_q;
    // The final word is the capture that happens once every read has been issued.
    assign pushLast = inflight_q && (issueCnt_q == '0);
    assign pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == READ) && (issueCnt_q != '0) && (pending < 3'd2);

    always_comb begin
        state_d    = state_q;
        romAddr_d  = romAddr_q;
        issueCnt_d = issueCnt_q;
        beatCnt_d  = beatCnt_q;
        busy_d     = busy_q;
        inflight_d = issue;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    romAddr_d  = base_addr_i;
                    issueCnt_d = length_i;
                    beatCnt_d  = length_i;
                    busy_d     = 1'b1;
                    state_d    = (length_i != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (issue) begin
                    romAddr_d  = romAddr_q + ADDR_WIDTH'(1);
                    issueCnt_d = issueCnt_q - LEN_WIDTH'(1);
                end
                if (pop) begin
                    beatCnt_d = beatCnt_q - LEN_WIDTH'(1);
                end
                if (pop && last_o) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry FIFO: head drives the outputs and only changes on a pop or when empty.
    always_comb begin
        head_d     = head_q;
        headLast_d = headLast_q;
        tail_d     = tail_q;
        tailLast_d = tailLast_q;
        occ_d      = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d     = rom_data_i;
                    headLast_d = pushLast;
                end else begin
                    tail_d     = rom_data_i;
                    tailLast_d = pushLast;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d     = tail_q;
                headLast_d = tailLast_q;
                occ_d      = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    head_d     = tail_q;
                    headLast_d = tailLast_q;
                    tail_d     = rom_data_i;
                    tailLast_d = pushLast;
                end else begin
                    head_d     = rom_data_i;
                    headLast_d = pushLast;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            romAddr_q  <= '0;
            issueCnt_q <= '0;
            beatCnt_q  <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            head_q     <= '0;
            headLast_q <= 1'b0;
            tail_q     <= '0;
            tailLast_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            romAddr_q  <= romAddr_d;
            issueCnt_q <= issueCnt_d;
            beatCnt_q  <= beatCnt_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            head_q     <= head_d;
            headLast_q <= headLast_d;
            tail_q     <= tail_d;
            tailLast_q <= tailLast_d;
            occ_q      <= occ_d;
        end
    end

`ifdef ROM_READER_STALL_CNT_EN
    logic [15:0] stallCnt_q;

    // Saturating count of stalled output cycles, restarted by each accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= 16'h0000;
        end else if ((state_q == IDLE) && start_i) begin
            stallCnt_q <= 16'h0000;
        end else if (valid_o && !ready_i && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'h0001;
        end
    end

    assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_rom_burst_reader_sv.sv
// Scoreboard bench for rom_burst_reader_sv: directed test-plan bursts plus random bursts.
// Expected beats come from a plain ROM-contents model indexed modulo depth.
module tb_rom_burst_reader_sv;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LW = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] length_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i = '0;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic          last_o;
`ifdef ROM_READER_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    always #5 clk = ~clk;

    rom_burst_reader_sv #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .length_i    (length_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o)
`ifdef ROM_READER_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    logic [DW-1:0] romMem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) romMem[i] = 8'h10 + DW'(i);

    always @(posedge clk) rom_data_i <= romMem[rom_addr_o];

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t expQ[$];
    int    expDone = 0;
    int    expStall = 0;
    bit    modelBusy = 0;
    int    compared = 0;
    int    mismatched = 0;
    int    readyMode = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a burst is simply len consecutive ROM words starting at base, wrapping.
    task automatic pushBurst(input int base, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = romMem[(base + i) % DEPTH];
            b.last = (i == len - 1);
            expQ.push_back(b);
        end
        expDone++;
    endtask

    task automatic applyStimulus(input int base, input int len);
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        length_i    = LW'(len);
        if (!modelBusy) begin
            pushBurst(base, len);
            modelBusy = 1;
            expStall  = 0;
        end
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
        length_i    = LW'($urandom);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (modelBusy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (modelBusy) begin
            checkOutput("idle_timeout", 32'(modelBusy), 32'd0);
            modelBusy = 0;
        end
    endtask

    task automatic doResetChecks(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
        checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
        checkOutput({tag, "_valid"}, 32'(valid_o), 32'd0);
        checkOutput({tag, "_last"}, 32'(last_o), 32'd0);
        checkOutput({tag, "_data"}, 32'(data_o), 32'd0);
        checkOutput({tag, "_addr"}, 32'(rom_addr_o), 32'd0);
    endtask

    initial begin
        logic pat [6];
        int ph;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ph = 0;
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: ready_i = 1'b1;
                1: begin
                    ready_i = pat[ph % 6];
                    ph++;
                end
                default: ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks hold and done behaviour.
    logic          prevStall = 1'b0;
    logic          prevDone = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic          prevLast = 1'b0;

    always @(negedge clk) begin : monitor
        beat_t b;
        if (!rst_n) begin
            prevStall = 1'b0;
            prevDone  = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_valid", 32'(valid_o), 32'd1);
                checkOutput("hold_data", 32'(data_o), 32'(prevData));
                checkOutput("hold_last", 32'(last_o), 32'(prevLast));
            end
            if (valid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_valid", 32'(valid_o), 32'd0);
                end else if (ready_i) begin
                    b = expQ.pop_front();
                    checkOutput("data", 32'(data_o), 32'(b.data));
                    checkOutput("last", 32'(last_o), 32'(b.last));
                end
            end
            if (done_o) begin
                checkOutput("done_drained", 32'(expQ.size()), 32'd0);
                checkOutput("done_expected", 32'(expDone > 0), 32'd1);
                checkOutput("done_width", 32'(prevDone), 32'd0);
`ifdef ROM_READER_STALL_CNT_EN
                checkOutput("stall_cnt", 32'(stall_cnt_o), 32'(expStall));
`endif
                if (expDone > 0) expDone--;
                modelBusy = 0;
            end
            if (valid_o && !ready_i && expStall < 65535) expStall++;
            prevStall = valid_o && !ready_i;
            prevData  = data_o;
            prevLast  = last_o;
            prevDone  = done_o;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        start_i     = 1'b0;
        base_addr_i = '0;
        length_i    = '0;
        rst_n       = 1'b0;
        #1;
        doResetChecks("reset");
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Test 1: basic burst with latency check.
        $display("[TB] basic burst base=3 len=4");
        readyMode = 0;
        applyStimulus(3, 4);
        @(negedge clk);
        checkOutput("lat_e0_valid", 32'(valid_o), 32'd0);
        checkOutput("lat_e0_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        checkOutput("lat_e1_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        checkOutput("lat_e2_valid", 32'(valid_o), 32'd1);
        checkOutput("lat_e2_data", 32'(data_o), 32'h13);
        waitIdle();

        $display("[TB] wrap burst base=14 len=4");
        applyStimulus(14, 4);
        waitIdle();

        $display("[TB] backpressure burst base=0 len=8");
        readyMode = 1;
        applyStimulus(0, 8);
        waitIdle();
        readyMode = 0;

        // Zero length: done one cycle after the start edge, no data.
        $display("[TB] zero length burst");
        applyStimulus(7, 0);
        @(negedge clk);
        checkOutput("zero_done", 32'(done_o), 32'd1);
        checkOutput("zero_valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        checkOutput("zero_done_end", 32'(done_o), 32'd0);
        waitIdle();

        $display("[TB] start while busy");
        applyStimulus(0, 16);
        repeat (3) @(posedge clk);
        applyStimulus(9, 2);
        waitIdle();

        $display("[TB] reset mid-burst");
        applyStimulus(0, 16);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        expDone   = 0;
        modelBusy = 0;
        #1;
        doResetChecks("midrst");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        applyStimulus(5, 1);
        waitIdle();

        // Full depth: busy stays high for exactly 18 cycles after the start edge.
        $display("[TB] full depth burst");
        applyStimulus(0, 16);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            n++;
        end
        checkOutput("full_busy_cycles", 32'(n), 32'd18);
        checkOutput("full_done_at_fall", 32'(done_o), 32'd1);
        waitIdle();

        $display("[TB] random bursts");
        for (int k = 0; k < 40; k++) begin
            readyMode = 2;
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 16));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                applyStimulus($urandom_range(0, 15), $urandom_range(0, 16));
            end
            waitIdle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        readyMode = 0;
        repeat (5) @(posedge clk);
        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("final_done_pending", 32'(expDone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader_sv.md
Name: rom_burst_reader_sv

Overview:
Sequencer for a synchronous single-port ROM with 1-cycle registered read latency. It accepts a burst command (base address and length), drives the ROM address for each read and captures the returned words. Words are streamed out over a valid/ready interface through an internal 2-entry buffer. Sits between a DMA/CPU-side command source and a ROM instance, so consumers never handle ROM latency or backpressure themselves.

Parameters:
DATA_WIDTH, 8, width of ROM words and output data
ADDR_WIDTH, 4, ROM address width; ROM depth = 2**ADDR_WIDTH
LEN_WIDTH, ADDR_WIDTH+1, burst length width; max burst = 2**ADDR_WIDTH words

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  command strobe; sampled only in IDLE
base_addr_i  input  ADDR_WIDTH  first ROM address of burst
length_i  input  LEN_WIDTH  number of words; 0 is legal
busy_o  output  1  high while a burst is active
done_o  output  1  one-cycle pulse at burst completion
rom_addr_o  output  ADDR_WIDTH  address to ROM read_addr_i
rom_data_i  input  DATA_WIDTH  ROM read_data_o, valid the cycle after address presented
data_o  output  DATA_WIDTH  streamed word
valid_o  output  1  data_o valid
ready_i  input  1  consumer accepts when valid_o & ready_i
last_o  output  1  qualifies final word of burst (meaningful when valid_o)

Behaviour:
- Reset (async, any state): state=IDLE; busy_o=0, done_o=0, valid_o=0, last_o=0, data_o=0, rom_addr_o=0; buffer emptied; in-flight flag, remaining-issue and remaining-beat counters cleared.
- States: IDLE, READ, DONE.
- IDLE: on start_i=1 at an edge, latch rom_addr_o<=base_addr_i, issue_cnt<=length_i and beat_cnt<=length_i, and set busy_o<=1.
  - Next state: READ if length_i!=0, else DONE.
- READ, issue rule: issue=(issue_cnt!=0) && (occ + inflight - pop) < 2, where occ=buffer occupancy (0..2) and pop=valid_o&ready_i.
- READ, on issue: rom_addr_o increments modulo 2**ADDR_WIDTH (15 wraps to 0), issue_cnt decrements, and inflight<=1; otherwise inflight<=0.
- Capture: when inflight=1, rom_data_i is pushed into the buffer at that edge. The ROM reads every cycle; data is captured only when inflight=1.
- Buffer: 2-entry FIFO, order preserved. data_o/valid_o come from the head register. data_o and last_o must hold stable while valid_o=1 && ready_i=0. Overflow is impossible by the issue rule.
- Per-entry last flag: set on the word whose capture brings captured count to length_i.
- beat_cnt decrements on each pop. When the last word pops (pop && last_o), next state is DONE.
- DONE: done_o=1 for exactly one cycle, busy_o<=0, then IDLE. done_o is registered (asserted the cycle after the final handshake).
- Latency: start edge E0 → rom_addr_o=base after E0 → capture at E1+1 edge → valid_o high 2 cycles after E0. Steady state with ready_i=1: one word per cycle, no bubbles.
- start_i is ignored while busy_o=1 (including DONE).
- Length 0: no ROM capture and no valid_o; done_o pulses the cycle after the start edge.
- Command inputs (base_addr_i, length_i) are sampled only at the start edge; later changes have no effect.

Optional Feature:
ROM_READER_STALL_CNT_EN: when defined, adds output port stall_cnt_o (16 bits).
- Counts cycles with valid_o=1 && ready_i=0 during a burst.
- Cleared to 0 at each accepted start and on reset.
- Saturates at 16'hFFFF.
- Holds its value after done until the next start.
When undefined, the port and counter logic are absent and behaviour is otherwise identical.

Test Plan:
1. ROM init word[i]=8'h10+i; base=3, len=4, ready_i=1 → data 8'h13,14,15,16 on consecutive cycles, first valid 2 cycles after start edge, last_o on 8'h16, done_o pulse next cycle, busy_o falls with it.
2. Wrap: base=14, len=4 → addresses 14,15,0,1; data 8'h1E,1F,10,11; last on 8'h11.
3. Backpressure: base=0, len=8, ready_i toggles 1,0,0,1,0,1… → exactly 8'h10..17 once each, in order; data_o/valid_o stable during every stall; occupancy never exceeds 2; with macro, stall_cnt_o equals counted stall cycles.
4. Zero length: start, len=0 → valid_o stays 0, done_o pulses one cycle after start, rom_data_i never captured.
5. Start while busy: second start_i (base=9, len=2) during a len=16 burst → ignored, full 16-word burst 8'h10..1F completes. Then assert rst_n=0 mid-burst → all outputs 0 immediately; after release, new burst base=5, len=1 → single word 8'h15 with last_o=1.
6. Full depth: base=0, len=16, ready_i=1 → 16 back-to-back beats, done_o at beat 16+1 cycle, busy_o high for exactly 18 cycles after start edge.
